adc_multi2streaming: RTL and testbench

Multi-channel, parametrised converter from latched ADC outputs to a ready/valid stream. The block synchronises an external `sinc` strobe and detects a selectable edge on it. On qualifying edges, after optional decimation, it captures one frame of N_CH words and buffers frames in a small FIFO. It emits each frame as channel-serial words with backpressure and reports dropped frames. It sits between the ADC capture logic and the streaming processing chain.

---
 rtl/adc_multi2streaming.sv | 133 +++++++++++++
 tb/tb_adc_multi2streaming.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multi2streaming.sv
// Latched multi-channel ADC words to a ready/valid stream: synchronised sinc edge detect,
// decimation, frame FIFO and a channel-serial output with sticky drop reporting.
module adc_multi2streaming #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sinc,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic                     enable,
  input  logic [15:0]              decim,
  input  logic                     clear_overflow,
  output logic [DATA_W-1:0]        data_out0,
  output logic                     data_out_valid0,
  input  logic                     data_ready0,
  output logic [CH_W-1:0]          channel_out,
  output logic                     last_out,
  output logic                     overflow,
  output logic [LVL_W-1:0]         fifo_level
);

  localparam int unsigned FRAME_W = N_CH * DATA_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned ARM_W   = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [FRAME_W-1:0]     dly_q [SYNC_STAGES];
  logic [FRAME_W-1:0]     cap_data_q;
  logic                   edge_q;
  logic [ARM_W-1:0]       arm_q;
  logic [15:0]            dcnt_q;
  logic [FRAME_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [LVL_W-1:0]       level_q;
  logic [CH_W-1:0]        ch_q;
  logic                   overflow_q;

  logic                   sync_last, edge_raw, armed;
  logic                   valid, last, xfer, pop, capture, push, drop;
  logic [DATA_W-1:0]      head_words [N_CH];

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_q == ARM_W'(SYNC_STAGES + 1));

  always_comb begin
    edge_raw = 1'b0;
    if (EDGE_MODE == 0)      edge_raw = sync_last & ~prev_q;
    else if (EDGE_MODE == 1) edge_raw = ~sync_last & prev_q;
    else                     edge_raw = sync_last ^ prev_q;
  end

  assign valid   = (level_q != '0);
  assign last    = (ch_q == CH_W'(N_CH - 1));
  assign xfer    = valid & data_ready0;
  assign pop     = xfer & last;
  assign capture = edge_q & enable & (dcnt_q >= decim);
  // A full FIFO still accepts a frame when the head frame leaves in the same cycle.
  assign push    = capture & ((level_q != LVL_W'(FIFO_DEPTH)) | pop);
  assign drop    = capture & ~push;

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      head_words[c] = mem_q[rptr_q][c*DATA_W +: DATA_W];
    end
  end

  assign data_out0       = head_words[ch_q];
  assign data_out_valid0 = valid;
  assign channel_out     = ch_q;
  assign last_out        = last;
  assign overflow        = overflow_q;
  assign fifo_level      = level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      cap_data_q <= '0;
      edge_q     <= 1'b0;
      arm_q      <= '0;
      dcnt_q     <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) dly_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sinc};
      prev_q <= sync_last;
      dly_q[0] <= data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) dly_q[i] <= dly_q[i-1];
      // Registering data with the edge keeps the frame aligned to the first sinc sample.
      cap_data_q <= dly_q[SYNC_STAGES-1];
      edge_q     <= armed & edge_raw;
      if (!armed) arm_q <= arm_q + ARM_W'(1);
      if (!enable) begin
        dcnt_q <= '0;
      end else if (edge_q) begin
        if (dcnt_q >= decim) dcnt_q <= '0;
        else                 dcnt_q <= dcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ch_q       <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= cap_data_q;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (xfer) begin
        if (last) ch_q <= '0;
        else      ch_q <= ch_q + CH_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_multi2streaming.sv
// Directed plus randomized bench for adc_multi2streaming against a frame-queue reference model.
module tb_adc_multi2streaming;

  localparam int unsigned DW = 32, NCH = 2, DEPTH = 8, SS = 2;

  logic        clk = 1'b0, reset = 1'b1, sinc = 1'b0, enable = 1'b1;
  logic        clear_overflow = 1'b0, data_ready0 = 1'b1;
  logic [63:0] data_in = '0;
  logic [15:0] decim = '0;

  logic [31:0] data_out0, b_data, f_data;
  logic        data_out_valid0, b_valid, f_valid;
  logic [0:0]  channel_out, b_ch, f_ch;
  logic        last_out, b_last, f_last, overflow, b_ovf, f_ovf;
  logic [3:0]  fifo_level, b_level, f_level;

  adc_multi2streaming #(.EDGE_MODE(0)) u_dut (
    .clk(clk), .reset(reset), .sinc(sinc), .data_in(data_in), .enable(enable), .decim(decim),
    .clear_overflow(clear_overflow), .data_out0(data_out0), .data_out_valid0(data_out_valid0),
    .data_ready0(data_ready0), .channel_out(channel_out), .last_out(last_out),
    .overflow(overflow), .fifo_level(fifo_level)
  );
  adc_multi2streaming #(.EDGE_MODE(2)) u_dut_both (
    .clk(clk), .reset(reset), .sinc(sinc), .data_in(data_in), .enable(enable), .decim(decim),
    .clear_overflow(clear_overflow), .data_out0(b_data), .data_out_valid0(b_valid),
    .data_ready0(data_ready0), .channel_out(b_ch), .last_out(b_last),
    .overflow(b_ovf), .fifo_level(b_level)
  );
  adc_multi2streaming #(.EDGE_MODE(1)) u_dut_fall (
    .clk(clk), .reset(reset), .sinc(sinc), .data_in(data_in), .enable(enable), .decim(decim),
    .clear_overflow(clear_overflow), .data_out0(f_data), .data_out_valid0(f_valid),
    .data_ready0(data_ready0), .channel_out(f_ch), .last_out(f_last),
    .overflow(f_ovf), .fifo_level(f_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {int at; bit lvl; logic [63:0] d;} ev_t;
  ev_t         pend[$];
  logic [63:0] fq[$];
  int          cyc, mch, dcount, checks, errors, words;
  bit          mov, last_sinc, data_fixed;
  logic [63:0] d_rise, d_fall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    cyc = 0; mch = 0; dcount = 0; mov = 0; last_sinc = 0;
  endtask

  // Frame-level reference: each sampled sinc change becomes a capture event SS+1 edges later.
  task automatic model_update();
    ev_t ev;
    bit  qual, cap, pop, drop;
    int  sz;
    logic [63:0] cd;
    qual = 0; cap = 0; pop = 0; drop = 0; cd = '0;
    cyc++;
    if (pend.size() > 0 && pend[0].at == cyc) begin
      ev = pend.pop_front();
      qual = ev.lvl;
      cd = ev.d;
    end
    if (!enable) dcount = 0;
    else if (qual) begin
      if (dcount >= int'(decim)) begin cap = 1; dcount = 0; end
      else dcount++;
    end
    sz = fq.size();
    if (sz > 0 && data_ready0) begin
      if (mch == NCH - 1) begin pop = 1; mch = 0; end
      else mch++;
    end
    if (pop) void'(fq.pop_front());
    if (cap) begin
      if (sz < DEPTH || pop) fq.push_back(cd);
      else drop = 1;
    end
    if (drop) mov = 1;
    else if (clear_overflow) mov = 0;
    if (sinc !== last_sinc) begin
      last_sinc = sinc;
      if (cyc >= 2) pend.push_back('{cyc + SS + 1, sinc, data_in});
    end
  endtask

  task automatic check_outputs();
    logic [63:0] f;
    chk("valid", 64'(data_out_valid0), 64'(fq.size() != 0));
    chk("level", 64'(fifo_level), 64'(fq.size()));
    chk("overflow", 64'(overflow), 64'(mov));
    chk("channel", 64'(channel_out), 64'(mch));
    chk("last", 64'(last_out), 64'(mch == NCH - 1));
    if (fq.size() != 0) begin
      f = fq[0];
      chk("data", 64'(data_out0), 64'(f[mch*DW +: DW]));
    end
  endtask

  task automatic step();
    if (!reset && data_out_valid0 && data_ready0) words++;
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
    check_outputs();
    if (!data_fixed) data_in = {$urandom, $urandom};
  endtask

  task automatic hold(input bit v, input int n);
    sinc = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(data_out_valid0), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_channel", 64'(channel_out), 64'(0));
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int hcnt;
    checks = 0; errors = 0; words = 0; data_fixed = 0;
    model_reset();
    step();
    step();
    chk("rst_data", 64'(data_out0), 64'(0));
    chk("rst_last", 64'(last_out), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    reset = 1'b0;

    // Basic frame: latency SS+1 and channel order.
    repeat (3) step();
    data_fixed = 1;
    data_in = {32'h22, 32'h11};
    sinc = 1'b1;
    step();
    data_fixed = 0;
    step();
    step();
    chk("t1_valid_early", 64'(data_out_valid0), 64'(0));
    step();
    chk("t1_valid", 64'(data_out_valid0), 64'(1));
    chk("t1_w0", 64'(data_out0), 64'(32'h11));
    chk("t1_last0", 64'(last_out), 64'(0));
    step();
    chk("t1_w1", 64'(data_out0), 64'(32'h22));
    chk("t1_ch1", 64'(channel_out), 64'(1));
    chk("t1_last1", 64'(last_out), 64'(1));
    step();
    chk("t1_empty", 64'(data_out_valid0), 64'(0));
    hold(0, 4);

    // Decimation by 4, then enable gap.
    decim = 16'd3;
    words = 0;
    repeat (12) begin hold(1, 4); hold(0, 4); end
    repeat (6) step();
    chk("decim_words", 64'(words), 64'(6));
    words = 0;
    for (int i = 1; i <= 10; i++) begin
      enable = !(i == 5 || i == 6);
      hold(1, 4);
      hold(0, 4);
    end
    enable = 1'b1;
    repeat (6) step();
    chk("enable_gap_words", 64'(words), 64'(4));

    // Overflow with ready held low, clear, then full drain.
    decim = 16'd0;
    data_ready0 = 1'b0;
    words = 0;
    repeat (9) begin hold(1, 3); hold(0, 3); end
    chk("ovf_level", 64'(fifo_level), 64'(8));
    chk("ovf_flag", 64'(overflow), 64'(1));
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'(0));
    data_ready0 = 1'b1;
    repeat (20) step();
    chk("drain_words", 64'(words), 64'(16));

    // Full FIFO accepts a capture in the same cycle as a pop.
    data_ready0 = 1'b0;
    repeat (8) begin hold(1, 3); hold(0, 3); end
    chk("full_level", 64'(fifo_level), 64'(8));
    sinc = 1'b1;
    step();
    step();
    data_ready0 = 1'b1;
    step();
    step();
    data_ready0 = 1'b0;
    chk("coincide_level", 64'(fifo_level), 64'(8));
    chk("coincide_ovf", 64'(overflow), 64'(0));
    data_ready0 = 1'b1;
    repeat (20) step();
    chk("coincide_drain", 64'(fifo_level), 64'(0));
    hold(0, 4);

    // Edge modes: four toggles of sinc.
    data_ready0 = 1'b0;
    do_reset();
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) d_rise = data_in;
      if (i == 1) d_fall = data_in;
      sinc = ~sinc;
      repeat (4) step();
    end
    repeat (4) step();
    chk("mode_rise_level", 64'(fifo_level), 64'(2));
    chk("mode_both_level", 64'(b_level), 64'(4));
    chk("mode_fall_level", 64'(f_level), 64'(2));
    chk("mode_both_data", 64'(b_data), 64'(d_rise[31:0]));
    chk("mode_fall_data", 64'(f_data), 64'(d_fall[31:0]));
    chk("mode_both_misc", 64'({b_valid, b_ch, b_last, b_ovf}), 64'(4'b1000));
    chk("mode_fall_misc", 64'({f_valid, f_ch, f_last, f_ovf}), 64'(4'b1000));

    // sinc held high through reset gives no capture.
    sinc = 1'b1;
    do_reset();
    repeat (8) step();
    chk("sinc_hi_rst_level", 64'(fifo_level), 64'(0));

    // Reset mid-frame after ch0 has gone.
    data_ready0 = 1'b1;
    hold(0, 4);
    sinc = 1'b1;
    for (int i = 0; i < 20 && channel_out != 1'b1; i++) step();
    chk("midframe_ch", 64'(channel_out), 64'(1));
    do_reset();
    hold(0, 4);
    sinc = 1'b1;
    for (int i = 0; i < 20 && !data_out_valid0; i++) step();
    chk("after_rst_valid", 64'(data_out_valid0), 64'(1));
    chk("after_rst_ch", 64'(channel_out), 64'(0));
    repeat (4) step();

    // Randomized traffic.
    hold(0, 4);
    do_reset();
    repeat (3) step();
    hcnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (hcnt == 0) begin
        sinc = 1'($urandom_range(0, 1));
        hcnt = $urandom_range(1, 4);
      end
      hcnt--;
      data_ready0 = ($urandom % 4) != 0;
      enable = ($urandom % 16) != 0;
      clear_overflow = ($urandom % 16) == 0;
      if ((i % 50) == 0) decim = 16'($urandom_range(0, 2));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
